// File: rtl/mvu_ram_rd_arbiter.sv
// mvu_ram_rd_arbiter: round-robin arbiter and burst sequencer for the MVU RAM
// read port. Grants one requester at a time, issues its burst one address per
// cycle, and returns RAM read data tagged with the owning requester one cycle
// after each issue (registered RAM read latency).
module mvu_ram_rd_arbiter #(
  parameter int unsigned BDADDR = 12,
  parameter int unsigned BDWORD = 2048,
  parameter int unsigned NREQ   = 2,
  parameter int unsigned BDLEN  = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*BDADDR-1:0]   i_req_addr,
  input  logic [NREQ*BDLEN-1:0]    i_req_len,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_ram_rd_en,
  output logic [BDADDR-1:0]        o_ram_rd_addr,
  input  logic [BDWORD-1:0]        i_ram_rd_word,
  output logic [NREQ-1:0]          o_rsp_valid,
  output logic                     o_rsp_last,
  output logic [BDWORD-1:0]        o_rsp_word,
  output logic                     o_busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_owner;
  logic [BDLEN-1:0]    r_remaining;
  logic                r_rd_en;
  logic [BDADDR-1:0]   r_rd_addr;
  logic [NREQ-1:0]     r_rsp_valid;
  logic                r_rsp_last;

  logic                w_found;
  logic [PW-1:0]       w_grant;
  logic [PW-1:0]       w_idx;
  logic [BDADDR-1:0]   w_base;
  logic [BDLEN-1:0]    w_len;
  logic                w_final;
  logic                w_accept;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = PW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Select base address and length of the winning requester
  always_comb begin
    w_base = '0;
    w_len  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == PW'(i)) begin
        w_base = i_req_addr[i*BDADDR +: BDADDR];
        w_len  = i_req_len[i*BDLEN +: BDLEN];
      end
    end
  end

  // A new burst may start from idle or overlap the last issue of the current one
  assign w_final     = (r_state == S_BURST) && (r_remaining == '0);
  assign w_accept    = !i_rst && ((r_state == S_IDLE) || w_final) && w_found;
  assign o_req_ready = w_accept ? (NREQ'(1) << w_grant) : '0;

  // Burst FSM, RAM read issue and response pipeline
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= PW'(NREQ - 1);
      r_owner     <= '0;
      r_remaining <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rsp_valid <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_rsp_valid <= r_rd_en ? (NREQ'(1) << r_owner) : '0;
      r_rsp_last  <= r_rd_en && (r_remaining == '0);
      if (w_accept) begin
        r_state     <= S_BURST;
        r_ptr       <= w_grant;
        r_owner     <= w_grant;
        r_remaining <= w_len;
        r_rd_en     <= 1'b1;
        r_rd_addr   <= w_base;
      end else if (r_state == S_BURST) begin
        if (w_final) begin
          r_state <= S_IDLE;
          r_rd_en <= 1'b0;
        end else begin
          r_rd_addr   <= r_rd_addr + BDADDR'(1);
          r_remaining <= r_remaining - BDLEN'(1);
        end
      end
    end
  end

  assign o_ram_rd_en   = r_rd_en;
  assign o_ram_rd_addr = r_rd_addr;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_last    = r_rsp_last;
  assign o_rsp_word    = i_ram_rd_word;
  assign o_busy        = (r_state == S_BURST);

endmodule

// File: tb/tb_mvu_ram_rd_arbiter.sv
// Bench for mvu_ram_rd_arbiter: cycle model plus response scoreboard, driven
// by directed request sequences.
module tb_mvu_ram_rd_arbiter;

  localparam int unsigned BDADDR = 12;
  localparam int unsigned BDWORD = 2048;
  localparam int unsigned NREQ   = 3;
  localparam int unsigned BDLEN  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]        tb_valid = '0;
  logic [BDADDR-1:0]      tb_addr [NREQ] = '{default: '0};
  logic [BDLEN-1:0]       tb_len  [NREQ] = '{default: '0};
  logic [NREQ*BDADDR-1:0] req_addr;
  logic [NREQ*BDLEN-1:0]  req_len;
  logic [NREQ-1:0]        o_req_ready;
  logic                   o_ram_rd_en;
  logic [BDADDR-1:0]      o_ram_rd_addr;
  logic [BDWORD-1:0]      ram_q = '0;
  logic [NREQ-1:0]        o_rsp_valid;
  logic                   o_rsp_last;
  logic [BDWORD-1:0]      o_rsp_word;
  logic                   o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_left [NREQ];

  typedef struct {
    int                owner;
    logic [BDADDR-1:0] addr;
    logic              last;
  } exp_t;
  exp_t q[$];

  int                grant_log[$];
  int                rdy_cyc[$];
  logic [BDADDR-1:0] addr_log[$];
  logic [NREQ-1:0]   rsp_log[$];

  // model state
  logic              m_busy    = 1'b0;
  logic [BDADDR-1:0] m_addr    = '0;
  logic [BDLEN-1:0]  m_rem     = '0;
  int                m_ptr     = NREQ - 1;
  logic              m_issue_d = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*BDADDR +: BDADDR] = tb_addr[i];
      req_len[i*BDLEN +: BDLEN]    = tb_len[i];
    end
  end

  mvu_ram_rd_arbiter #(
    .BDADDR(BDADDR), .BDWORD(BDWORD), .NREQ(NREQ), .BDLEN(BDLEN)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(tb_valid), .i_req_addr(req_addr), .i_req_len(req_len),
    .o_req_ready(o_req_ready),
    .o_ram_rd_en(o_ram_rd_en), .o_ram_rd_addr(o_ram_rd_addr),
    .i_ram_rd_word(ram_q),
    .o_rsp_valid(o_rsp_valid), .o_rsp_last(o_rsp_last), .o_rsp_word(o_rsp_word),
    .o_busy(o_busy)
  );

  function automatic logic [BDWORD-1:0] ram_f(input logic [BDADDR-1:0] a);
    logic [BDWORD-1:0] w;
    w = '0;
    for (int i = 0; i < BDWORD/32; i++) w[i*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ 32'(i);
    return w;
  endfunction

  // RAM with registered read, zero when not enabled
  always @(posedge clk) ram_q <= o_ram_rd_en ? ram_f(o_ram_rd_addr) : '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [BDWORD-1:0] obs, input logic [BDWORD-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Cycle model and scoreboard, evaluated away from the active edge
  always @(negedge clk) begin : mon
    int g;
    int idx;
    logic can;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    cyc++;
    g = -1;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (g < 0 && tb_valid[idx]) g = idx;
    end
    can = !rst && (!m_busy || m_rem == '0) && (g >= 0);
    exp_rdy = can ? (NREQ'(1) << g) : '0;
    check("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    check("rd_en", 64'(o_ram_rd_en), 64'(m_busy));
    check("busy", 64'(o_busy), 64'(m_busy));
    if (m_busy) check("rd_addr", 64'(o_ram_rd_addr), 64'(m_addr));
    if (m_issue_d) begin
      if (q.size() == 0) begin
        check("sb_nonempty", 64'(q.size() > 0), 64'(1));
      end else begin
        e = q.pop_front();
        check("rsp_valid", 64'(o_rsp_valid), 64'(NREQ'(1) << e.owner));
        check("rsp_last", 64'(o_rsp_last), 64'(e.last));
        check_word("rsp_word", o_rsp_word, ram_f(e.addr));
      end
    end else begin
      check("rsp_valid_idle", 64'(o_rsp_valid), 64'(0));
      check("rsp_last_idle", 64'(o_rsp_last), 64'(0));
    end
    for (int i = 0; i < NREQ; i++) if (o_req_ready[i]) grant_log.push_back(i);
    if (o_req_ready[0]) rdy_cyc.push_back(cyc);
    if (o_ram_rd_en) addr_log.push_back(o_ram_rd_addr);
    if (o_rsp_valid != '0) rsp_log.push_back(o_rsp_valid);
    // advance model to the next cycle
    if (rst) begin
      m_busy = 1'b0; m_rem = '0; m_ptr = NREQ - 1; m_issue_d = 1'b0;
      q.delete();
    end else begin
      m_issue_d = m_busy;
      if (can) begin
        m_busy = 1'b1; m_addr = tb_addr[g]; m_rem = tb_len[g]; m_ptr = g;
        for (int k = 0; k <= int'(tb_len[g]); k++) begin
          e.owner = g;
          e.addr  = tb_addr[g] + BDADDR'(k);
          e.last  = (k == int'(tb_len[g]));
          q.push_back(e);
        end
      end else if (m_busy) begin
        if (m_rem == '0) m_busy = 1'b0;
        else begin m_addr = m_addr + BDADDR'(1); m_rem = m_rem - BDLEN'(1); end
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete(); rdy_cyc.delete(); addr_log.delete(); rsp_log.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; tb_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  // Hold requests until accepted; reissue with a new address until counts reach zero
  task automatic serve(input int max_cyc);
    int c;
    int pend;
    logic [NREQ-1:0] rdy;
    c = 0;
    pend = 0;
    for (int i = 0; i < NREQ; i++) pend += n_left[i];
    while (pend > 0 && c < max_cyc) begin
      @(negedge clk);
      rdy = o_req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i] && n_left[i] > 0) begin
          n_left[i]--;
          if (n_left[i] == 0) tb_valid[i] = 1'b0;
          else tb_addr[i] = tb_addr[i] + BDADDR'(16);
        end
      end
      pend = 0;
      for (int i = 0; i < NREQ; i++) pend += n_left[i];
      c++;
    end
    check("serve_pending", 64'(pend), 64'(0));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((o_busy || q.size() > 0) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain_sb_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    logic [BDADDR-1:0] wexp [4];

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_rd_en", 64'(o_ram_rd_en), 64'(0));
    check("rst_rd_addr", 64'(o_ram_rd_addr), 64'(0));
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_rsp_last", 64'(o_rsp_last), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));

    // Single request, 4-word burst
    do_reset();
    tb_addr[0] = 12'h010; tb_len[0] = 4'd3; tb_valid[0] = 1'b1;
    n_left = '{1, 0, 0};
    serve(20);
    drain();
    check("single_nwords", 64'(addr_log.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      check("single_addr", 64'((k < addr_log.size()) ? addr_log[k] : 12'hBAD), 64'(12'h010 + k));
    check("single_nrsp", 64'(rsp_log.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      check("single_owner", 64'((k < rsp_log.size()) ? rsp_log[k] : 3'b111), 64'(3'b001));

    // Simultaneous requests after reset
    do_reset();
    tb_addr[0] = 12'h100; tb_len[0] = 4'd0;
    tb_addr[1] = 12'h200; tb_len[1] = 4'd0;
    tb_valid = 3'b011;
    n_left = '{1, 1, 0};
    serve(20);
    drain();
    check("sim_grant0", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(0));
    check("sim_grant1", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(1));
    check("sim_addr0", 64'((addr_log.size() > 0) ? addr_log[0] : 12'hBAD), 64'(12'h100));
    check("sim_addr1", 64'((addr_log.size() > 1) ? addr_log[1] : 12'hBAD), 64'(12'h200));
    check("sim_rsp0", 64'((rsp_log.size() > 0) ? rsp_log[0] : 3'b111), 64'(3'b001));
    check("sim_rsp1", 64'((rsp_log.size() > 1) ? rsp_log[1] : 3'b111), 64'(3'b010));

    // Back-to-back bursts from one requester
    do_reset();
    tb_addr[0] = 12'h040; tb_len[0] = 4'd1; tb_valid[0] = 1'b1;
    n_left = '{4, 0, 0};
    serve(40);
    drain();
    check("b2b_nready", 64'(rdy_cyc.size()), 64'(4));
    for (int k = 0; k < 3; k++)
      check("b2b_gap", 64'((k + 1 < rdy_cyc.size()) ? rdy_cyc[k+1] - rdy_cyc[k] : -1), 64'(2));
    check("b2b_nwords", 64'(addr_log.size()), 64'(8));

    // Address wrap
    do_reset();
    tb_addr[0] = 12'hFFE; tb_len[0] = 4'd3; tb_valid[0] = 1'b1;
    n_left = '{1, 0, 0};
    serve(20);
    drain();
    wexp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    for (int k = 0; k < 4; k++)
      check("wrap_addr", 64'((k < addr_log.size()) ? addr_log[k] : 12'hBAD), 64'(wexp[k]));

    // Reset on the third issue cycle of an 8-word burst
    do_reset();
    tb_addr[0] = 12'h300; tb_len[0] = 4'd7; tb_valid[0] = 1'b1;
    c = 0;
    @(negedge clk);
    while (!o_req_ready[0] && c < 20) begin @(negedge clk); c++; end
    check("mid_accept", 64'(o_req_ready[0]), 64'(1));
    @(posedge clk); #1;
    tb_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    tb_addr[1] = 12'h500; tb_len[1] = 4'd0; tb_valid[1] = 1'b1;
    @(negedge clk);
    check("mid_issue3", 64'(o_ram_rd_addr), 64'(12'h302));
    check("mid_no_ready", 64'(o_req_ready), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rd_en", 64'(o_ram_rd_en), 64'(0));
    check("mid_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("mid_busy", 64'(o_busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    tb_addr[0] = 12'h600; tb_len[0] = 4'd0; tb_valid[0] = 1'b1;
    clear_logs();
    n_left = '{1, 1, 0};
    serve(20);
    drain();
    check("mid_first_grant", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'(0));
    check("mid_second_grant", 64'((grant_log.size() > 1) ? grant_log[1] : -1), 64'(1));

    // Fairness with three continuously valid requesters
    do_reset();
    tb_addr[0] = 12'h700; tb_addr[1] = 12'h710; tb_addr[2] = 12'h720;
    tb_len[0] = 4'd0; tb_len[1] = 4'd0; tb_len[2] = 4'd0;
    tb_valid = 3'b111;
    n_left = '{2, 2, 2};
    serve(40);
    drain();
    for (int k = 0; k < 6; k++)
      check("fair_grant", 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(k % 3));
    check("fair_nwords", 64'(addr_log.size()), 64'(6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
